// File: rtl/axi_lite_arb_pkg.sv
// Shared types and helpers for the AXI4-Lite command arbiter.
package axi_lite_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int OWNER_W     = $clog2(NUM_REQ_DEF);

    // Owner index width for a given requester count (never below one bit).
    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_lite_rr_pick.sv
// Combinational picker: first requester found after ptr_i, wrapping modulo NUM_REQ.
module axi_lite_rr_pick
    import axi_lite_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = owner_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]      idx_o
);

    logic [IW:0] cand;
    logic        found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            // ptr + k stays below 2*NUM_REQ, so one conditional subtract wraps it.
            cand = {1'b0, ptr_i} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end
            if (!found && req_i[cand[IW-1:0]]) begin
                found                   = 1'b1;
                grant_o[cand[IW-1:0]]   = 1'b1;
                idx_o                   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/axi_lite_cmd_arbiter.sv
// Shares one single-beat AXI4-Lite master command port among NUM_REQ requesters.
// Define AXI_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module axi_lite_cmd_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          busy,
    output logic                          m_start,
    output logic                          m_write_en,
    output logic [ADDR_WIDTH-1:0]         m_addr,
    output logic [DATA_WIDTH-1:0]         m_wdata,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic                          m_done
);

    localparam int IW = owner_w(NUM_REQ);

    arb_state_t            state_q, state_d;
    logic [IW-1:0]         owner_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [NUM_REQ-1:0]    win_oh;
    logic [IW-1:0]         win_idx;
    logic [IW-1:0]         ptr;
    logic                  accept;

`ifdef AXI_ARB_RR_EN
    logic [IW-1:0] ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= IW'(NUM_REQ-1);
        end else if (accept) begin
            ptr_q <= win_idx;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = IW'(NUM_REQ-1);
`endif

    axi_lite_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr),
        .grant_o (win_oh),
        .idx_o   (win_idx)
    );

    // Reset also gates the combinational grant so req_ready reads zero while rst is high.
    assign accept = !rst && (state_q == IDLE) && (|req_valid);

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_ready = win_oh;
                    state_d   = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (m_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = NUM_REQ'(1) << owner_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q <= win_idx;
                we_q    <= req_we[win_idx];
                addr_q  <= req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q <= req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            if ((state_q == WAIT) && m_done) begin
                rdata_q <= m_rdata;
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign m_start    = (state_q == ISSUE);
    assign m_write_en = we_q;
    assign m_addr     = addr_q;
    assign m_wdata    = wdata_q;
    assign rsp_rdata  = rdata_q;

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Self-checking bench for axi_lite_cmd_arbiter (honours AXI_ARB_RR_EN if defined).
module tb_axi_lite_cmd_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            busy;
    logic            m_start;
    logic            m_write_en;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [DW-1:0]   m_rdata = '0;
    logic            m_done = 1'b0;

    always #5 clk = ~clk;

    axi_lite_cmd_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .busy       (busy),
        .m_start    (m_start),
        .m_write_en (m_write_en),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_done     (m_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Requester-side view: pending commands held stable until granted.
    logic [N-1:0]  pend_v = '0;
    logic          pend_we[N];
    logic [31:0]   pend_addr[N];
    logic [31:0]   pend_wdata[N];
    int            last_grant = N-1;

    typedef struct {
        int          id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_req();
        for (int i = 0; i < N; i++) begin
            req_we[i]               = pend_we[i];
            req_addr[i*AW +: AW]    = pend_addr[i];
            req_wdata[i*DW +: DW]   = pend_wdata[i];
        end
        req_valid = pend_v;
    endtask

    task automatic set_req(input int id, input logic we, input logic [31:0] a, input logic [31:0] d);
        pend_we[id]    = we;
        pend_addr[id]  = a;
        pend_wdata[id] = d;
        pend_v[id]     = 1'b1;
    endtask

    // Reference policy: who should win given the pending set and the last grant.
    function automatic int model_pick(input logic [N-1:0] v, input int last);
`ifdef AXI_ARB_RR_EN
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    // Entered at a negedge drive point in IDLE with requests already driven;
    // returns at the drive point of the IDLE cycle following the response.
    task automatic serve(input int w, input bit keep, input logic [N-1:0] raise,
                         input bit spur, input logic [31:0] rd, input int lat);
        logic [N-1:0] oh;
        oh = 4'b0001 << w;
        #4;
        check("accept_ready", req_ready, oh);
        check("accept_start", m_start, 0);
        @(negedge clk);
        if (!keep) pend_v[w] = 1'b0;
        drive_req();
        m_done  = spur;
        m_rdata = ~rd;
        #4;
        check("issue_start", m_start, 1);
        check("issue_we", m_write_en, pend_we[w]);
        check("issue_addr", m_addr, pend_addr[w]);
        check("issue_wdata", m_wdata, pend_wdata[w]);
        check("issue_ready", req_ready, 0);
        check("issue_busy", busy, 1);
        @(negedge clk);
        m_done = 1'b0;
        pend_v = pend_v | raise;
        drive_req();
        for (int i = 0; i < lat; i++) begin
            #4;
            check("wait_start", m_start, 0);
            check("wait_rsp", rsp_valid, 0);
            check("wait_ready", req_ready, 0);
            check("wait_addr", m_addr, pend_addr[w]);
            check("wait_busy", busy, 1);
            @(negedge clk);
        end
        m_done  = 1'b1;
        m_rdata = rd;
        #4;
        check("done_rsp", rsp_valid, 0);
        @(negedge clk);
        m_done  = 1'b0;
        m_rdata = $urandom;
        #4;
        check("resp_valid", rsp_valid, oh);
        check("resp_rdata", rsp_rdata, rd);
        check("resp_ready", req_ready, 0);
        check("resp_busy", busy, 1);
        @(negedge clk);
    endtask

    initial begin
        int w;
        for (int i = 0; i < N; i++) begin
            pend_we[i]    = 1'b0;
            pend_addr[i]  = 32'h100 + 32'(i) * 4;
            pend_wdata[i] = 32'hA000_0000 + 32'(i);
        end
        vecs[0] = '{id: 2, we: 1'b0, addr: 32'h40, wdata: 32'h0,        rdata: 32'hDEADBEEF, lat: 2};
        vecs[1] = '{id: 1, we: 1'b1, addr: 32'h10, wdata: 32'h12345678, rdata: 32'h0BAD0BAD, lat: 1};
        vecs[2] = '{id: 0, we: 1'b0, addr: 32'hFFFF_FFFC, wdata: 32'h0, rdata: 32'hFFFFFFFF, lat: 0};
        vecs[3] = '{id: 3, we: 1'b1, addr: 32'h8000_0000, wdata: 32'hFFFFFFFF, rdata: 32'h1, lat: 3};
        vecs[4] = '{id: 3, we: 1'b0, addr: 32'h0,  wdata: 32'h5555AAAA, rdata: 32'h00000000, lat: 5};
        vecs[5] = '{id: 1, we: 1'b0, addr: 32'h24, wdata: 32'h0,        rdata: 32'hCAFEF00D, lat: 1};

        // Reset state, with every requester already asserting.
        pend_v = 4'b1111;
        drive_req();
        #3;
        check("rst_ready", req_ready, 0);
        check("rst_rsp", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_start", m_start, 0);
        check("rst_we", m_write_en, 0);
        check("rst_addr", m_addr, 0);
        check("rst_wdata", m_wdata, 0);
        check("rst_rdata", rsp_rdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // All four continuously requesting.
        for (int g = 0; g < 5; g++) begin
`ifdef AXI_ARB_RR_EN
            w = g % N;
`else
            w = 0;
`endif
            serve(w, 1'b1, '0, 1'b0, 32'h5000 + 32'(g), 1);
            last_grant = w;
        end
        pend_v = '0;
        drive_req();

        // Single-requester vector table.
        for (int v = 0; v < 6; v++) begin
            set_req(vecs[v].id, vecs[v].we, vecs[v].addr, vecs[v].wdata);
            drive_req();
            serve(vecs[v].id, 1'b0, '0, 1'b0, vecs[v].rdata, vecs[v].lat);
            last_grant = vecs[v].id;
        end

        // Spurious m_done while idle.
        m_done  = 1'b1;
        m_rdata = 32'h0000_0BAD;
        #4;
        check("spur_idle_busy", busy, 0);
        check("spur_idle_rsp", rsp_valid, 0);
        @(negedge clk);
        m_done = 1'b0;
        #4;
        check("spur_idle_busy2", busy, 0);
        check("spur_idle_rsp2", rsp_valid, 0);
        check("spur_idle_rdata", rsp_rdata, 32'hCAFEF00D);
        @(negedge clk);

        // Spurious m_done during the ISSUE cycle.
        set_req(2, 1'b0, 32'h44, 32'h0);
        drive_req();
        serve(2, 1'b0, '0, 1'b1, 32'h2222_4444, 2);
        last_grant = 2;

        // Requester 0 raises during requester 1's WAIT.
        pend_we[0]    = 1'b1;
        pend_addr[0]  = 32'h60;
        pend_wdata[0] = 32'h0606_0606;
        set_req(1, 1'b1, 32'h14, 32'h1111_1111);
        drive_req();
        serve(1, 1'b0, 4'b0001, 1'b0, 32'h7777_0001, 2);
        last_grant = 1;
        serve(0, 1'b0, '0, 1'b0, 32'h7777_0000, 1);
        last_grant = 0;

        // Asynchronous reset in the middle of WAIT.
        set_req(1, 1'b1, 32'h80, 32'h9999_9999);
        drive_req();
        #4;
        check("rstw_accept", req_ready, 4'b0010);
        @(negedge clk);
        pend_v = '0;
        drive_req();
        @(negedge clk);
        #4;
        check("rstw_in_wait", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rstw_busy", busy, 0);
        check("rstw_start", m_start, 0);
        check("rstw_we", m_write_en, 0);
        check("rstw_addr", m_addr, 0);
        check("rstw_wdata", m_wdata, 0);
        check("rstw_rdata", rsp_rdata, 0);
        check("rstw_rsp", rsp_valid, 0);
        @(negedge clk);
        rst        = 1'b0;
        last_grant = N-1;
        m_done     = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #4;
            check("rstw_post_rsp", rsp_valid, 0);
            check("rstw_post_busy", busy, 0);
            @(negedge clk);
        end
        set_req(3, 1'b0, 32'h3C, 32'h0);
        drive_req();
        serve(3, 1'b0, '0, 1'b0, 32'h3333_CCCC, 1);
        last_grant = 3;

        // Randomised traffic against the policy model.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend_v[i] && ($urandom_range(0, 1) == 1)) begin
                    set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
                end
            end
            if (pend_v == '0) begin
                set_req(int'($urandom_range(0, N-1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            end
            drive_req();
            w = model_pick(pend_v, last_grant);
            serve(w, 1'b0, '0, 1'b0, $urandom, int'($urandom_range(0, 3)));
            last_grant = w;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
